// File: rtl/vcode_engine.sv
// vcode_engine: per-frame CRC insert (MODE=0) or check-and-strip (MODE=1)
// for RIFL beat streams; 1-cycle latency, gap tolerant, abort on early sof.
module vcode_engine #(
   parameter int                   FRAME_WIDTH    = 256,
   parameter int                   DWIDTH         = 64,
   parameter int                   CRC_WIDTH      = 12,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY       = 12'h02f,
   parameter int                   FRAME_ID_WIDTH = 8,
   parameter bit                   MODE           = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic                      in_sof,
   input  logic [DWIDTH-1:0]         in_data,
   output logic                      out_valid,
   output logic                      out_sof,
   output logic                      out_tail,
   output logic [DWIDTH-1:0]         out_data,
   output logic                      crc_err,
   output logic                      frame_abort,
   output logic [FRAME_ID_WIDTH-1:0] frame_id_o
);

   localparam int BEATS = FRAME_WIDTH / DWIDTH;
   localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNTW-1:0] LAST = CNTW'(BEATS - 1);

   typedef enum logic {
      IDLE,
      IN_FRAME
   } state_e;

   state_e                    state_q, state_d;
   logic [CNTW-1:0]           cnt_q, cnt_d;
   logic [CRC_WIDTH-1:0]      crc_q, crc_d;
   logic [FRAME_ID_WIDTH-1:0] id_q, id_d;
   logic                      dtype_q, dtype_d;
   logic                      vld_q, vld_d;
   logic                      sof_q, sof_d;
   logic                      tail_q, tail_d;
   logic                      err_q, err_d;
   logic                      abort_q, abort_d;
   logic [DWIDTH-1:0]         data_q, data_d;

   logic                      is_data_hdr;
   logic                      in_fr;
   logic                      beat_tail;
   logic                      dtype_cur;
   logic [CRC_WIDTH-1:0]      crc_seed;
   logic [CRC_WIDTH-1:0]      crc_beat;
   logic [CRC_WIDTH-1:0]      code;
   logic [DWIDTH-1:0]         crc_in;

   function automatic logic [CRC_WIDTH-1:0] crc_next(
      input logic [CRC_WIDTH-1:0] c,
      input logic [DWIDTH-1:0]    d
   );
      logic [CRC_WIDTH-1:0] r;
      logic                 fb;
      r = c;
      for (int i = DWIDTH - 1; i >= 0; i--) begin
         fb = r[CRC_WIDTH-1] ^ d[i];
         r  = {r[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
      end
      return r;
   endfunction

   assign is_data_hdr = (in_data[DWIDTH-1 -: 2] == 2'b01);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      crc_d     = crc_q;
      id_d      = id_q;
      dtype_d   = dtype_q;
      vld_d     = in_valid;
      sof_d     = in_valid & in_sof;
      tail_d    = 1'b0;
      err_d     = 1'b0;
      abort_d   = 1'b0;
      data_d    = data_q;
      in_fr     = 1'b0;
      beat_tail = 1'b0;
      dtype_cur = dtype_q;
      crc_seed  = crc_q;
      if (in_valid) begin
         data_d = in_data;
         unique case (1'b1)
            in_sof: begin
               // An early sof drops the old frame and restarts on this beat
               abort_d   = (state_q == IN_FRAME);
               crc_seed  = '0;
               dtype_cur = is_data_hdr;
               dtype_d   = is_data_hdr;
               in_fr     = 1'b1;
               beat_tail = (BEATS == 1);
               cnt_d     = (BEATS == 1) ? '0 : CNTW'(1);
               state_d   = (BEATS == 1) ? IDLE : IN_FRAME;
            end
            (!in_sof && state_q == IN_FRAME): begin
               in_fr     = 1'b1;
               beat_tail = (cnt_q == LAST);
               cnt_d     = cnt_q + CNTW'(1);
            end
            default: ;
         endcase
      end
      crc_in = beat_tail ?
               {in_data[DWIDTH-1:CRC_WIDTH], {CRC_WIDTH{1'b0}}} :
               in_data;
      crc_beat = crc_next(crc_seed, crc_in);
      code     = crc_beat ^ CRC_WIDTH'(id_q);
      if (in_fr) begin
         if (beat_tail) begin
            tail_d  = 1'b1;
            crc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
            if (MODE == 1'b0) begin
               data_d = {in_data[DWIDTH-1:CRC_WIDTH], code};
            end else begin
               data_d = crc_in;
               err_d  = (in_data[CRC_WIDTH-1:0] != code);
            end
            // RX counts ids even on bad frames to stay aligned with TX
            if (dtype_cur) begin
               id_d = id_q + FRAME_ID_WIDTH'(1);
            end
         end else begin
            crc_d = crc_beat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         crc_q   <= '0;
         id_q    <= '0;
         dtype_q <= 1'b0;
         vld_q   <= 1'b0;
         sof_q   <= 1'b0;
         tail_q  <= 1'b0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         crc_q   <= crc_d;
         id_q    <= id_d;
         dtype_q <= dtype_d;
         vld_q   <= vld_d;
         sof_q   <= sof_d;
         tail_q  <= tail_d;
         err_q   <= err_d;
         abort_q <= abort_d;
         data_q  <= data_d;
      end
   end

   assign out_valid   = vld_q;
   assign out_sof     = sof_q;
   assign out_tail    = tail_q;
   assign out_data    = data_q;
   assign crc_err     = err_q;
   assign frame_abort = abort_q;
   assign frame_id_o  = id_q;

endmodule
